// File: rtl/fft_butterfly_radix_4_pipe_if.sv
// Radix-4 butterfly stream bus: input tuple handshake, output tuple handshake,
// and the overflow control/status pair.
// master: upstream/controller side (drives x_*, y_ready, cr_*); slave: the butterfly.
interface fft_butterfly_radix_4_pipe_if #(
  parameter int data_width_p = 16
);
  logic                           x_valid;
  logic                           x_ready;
  logic                           x_inverse;
  logic [1:0]                     x_shift;
  logic signed [data_width_p-1:0] x_a_re, x_a_im, x_b_re, x_b_im;
  logic signed [data_width_p-1:0] x_c_re, x_c_im, x_d_re, x_d_im;

  logic                           y_valid;
  logic                           y_ready;
  logic signed [data_width_p-1:0] y_a_re, y_a_im, y_b_re, y_b_im;
  logic signed [data_width_p-1:0] y_c_re, y_c_im, y_d_re, y_d_im;

  logic                           cr_clear_overflow;
  logic                           sr_overflow;

  modport master (
    output x_valid, x_inverse, x_shift,
    output x_a_re, x_a_im, x_b_re, x_b_im, x_c_re, x_c_im, x_d_re, x_d_im,
    input  x_ready,
    input  y_valid,
    input  y_a_re, y_a_im, y_b_re, y_b_im, y_c_re, y_c_im, y_d_re, y_d_im,
    output y_ready,
    output cr_clear_overflow,
    input  sr_overflow
  );

  modport slave (
    input  x_valid, x_inverse, x_shift,
    input  x_a_re, x_a_im, x_b_re, x_b_im, x_c_re, x_c_im, x_d_re, x_d_im,
    output x_ready,
    output y_valid,
    output y_a_re, y_a_im, y_b_re, y_b_im, y_c_re, y_c_im, y_d_re, y_d_im,
    input  y_ready,
    input  cr_clear_overflow,
    output sr_overflow
  );
endinterface

// File: rtl/fft_butterfly_radix_4_pipe.sv
// Pipelined radix-4 DIT butterfly with per-tuple fwd/inv, rounding shift, saturation.
// Latency 3 cycles from acceptance to y_valid; one tuple per cycle.
// Backpressure: whole pipe freezes while y_valid && !y_ready; x_ready mirrors that enable.
// Ports: clk, rst_n (async, active-low), bus (slave modport: x_* in, y_* out,
// cr_clear_overflow in, sr_overflow out).
module fft_butterfly_radix_4_pipe #(
  parameter int data_width_p = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fft_butterfly_radix_4_pipe_if.slave bus
);
  localparam int W  = data_width_p;
  localparam int W2 = W + 2;  // worst-case butterfly growth
  localparam int W3 = W + 3;  // headroom for the rounding add

  typedef logic signed [W2-1:0] wide_t;
  typedef logic signed [W3-1:0] rnd_t;

  localparam rnd_t sat_max = {{4{1'b0}}, {(W-1){1'b1}}};
  localparam rnd_t sat_min = {{4{1'b1}}, {(W-1){1'b0}}};

  function automatic wide_t ext(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  // Single global enable: every stage moves together, so bubbles stay put.
  logic en;
  logic y_valid_q;
  assign en          = !(y_valid_q && !bus.y_ready);
  assign bus.x_ready = en;

  // Component order used by every array below:
  // 0 a_re, 1 a_im, 2 b_re, 3 b_im, 4 c_re, 5 c_im, 6 d_re, 7 d_im
  wide_t      in_c [8];
  logic [1:0] k_in;

  always_comb begin
    in_c[0] = ext(bus.x_a_re);
    in_c[1] = ext(bus.x_a_im);
    in_c[2] = ext(bus.x_b_re);
    in_c[3] = ext(bus.x_b_im);
    in_c[4] = ext(bus.x_c_re);
    in_c[5] = ext(bus.x_c_im);
    in_c[6] = ext(bus.x_d_re);
    in_c[7] = ext(bus.x_d_im);
  end

  // Shift code 3 is clamped to 2 at the door so later stages only see 0..2.
  assign k_in = (bus.x_shift == 2'd3) ? 2'd2 : bus.x_shift;

  // ---------------- stage 1: s0=a+c, s1=a-c, s2=b+d, s3=b-d ----------------
  // s_q order: s0 re/im, s1 re/im, s2 re/im, s3 re/im
  wide_t      s_q [8];
  logic       v1_q;
  logic       inv1_q;
  logic [1:0] k1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  v1_q <= 1'b0;
    else if (en) v1_q <= bus.x_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      inv1_q <= bus.x_inverse;
      k1_q   <= k_in;
      s_q[0] <= in_c[0] + in_c[4];
      s_q[1] <= in_c[1] + in_c[5];
      s_q[2] <= in_c[0] - in_c[4];
      s_q[3] <= in_c[1] - in_c[5];
      s_q[4] <= in_c[2] + in_c[6];
      s_q[5] <= in_c[3] + in_c[7];
      s_q[6] <= in_c[2] - in_c[6];
      s_q[7] <= in_c[3] - in_c[7];
    end
  end

  // ---------------- stage 2: combine with the -j / +j kernel ----------------
  // p = s1 - j*s3 (forward X1), m = s1 + j*s3 (forward X3); inverse swaps them.
  wide_t p_re, p_im, m_re, m_im;
  wide_t x2_d [8];

  always_comb begin
    p_re    = s_q[2] + s_q[7];
    p_im    = s_q[3] - s_q[6];
    m_re    = s_q[2] - s_q[7];
    m_im    = s_q[3] + s_q[6];
    x2_d[0] = s_q[0] + s_q[4];
    x2_d[1] = s_q[1] + s_q[5];
    x2_d[4] = s_q[0] - s_q[4];
    x2_d[5] = s_q[1] - s_q[5];
    x2_d[2] = inv1_q ? m_re : p_re;
    x2_d[3] = inv1_q ? m_im : p_im;
    x2_d[6] = inv1_q ? p_re : m_re;
    x2_d[7] = inv1_q ? p_im : m_im;
  end

  wide_t      x2_q [8];
  logic       v2_q;
  logic [1:0] k2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  v2_q <= 1'b0;
    else if (en) v2_q <= v1_q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      k2_q <= k1_q;
      for (int i = 0; i < 8; i++) x2_q[i] <= x2_d[i];
    end
  end

  // ---------------- stage 3: round half up, shift, saturate ----------------
  rnd_t                  rnd_c;
  rnd_t                  r_c [8];
  rnd_t                  v_c [8];
  logic signed [W-1:0]   y_d [8];
  logic [7:0]            sat_c;

  always_comb begin
    rnd_c = '0;
    if (k2_q == 2'd1)      rnd_c[0] = 1'b1;
    else if (k2_q == 2'd2) rnd_c[1] = 1'b1;
    sat_c = '0;
    for (int i = 0; i < 8; i++) begin
      r_c[i] = {x2_q[i][W2-1], x2_q[i]} + rnd_c;
      v_c[i] = r_c[i] >>> k2_q;
      y_d[i] = v_c[i][W-1:0];
      if (v_c[i] > sat_max) begin
        y_d[i]   = sat_max[W-1:0];
        sat_c[i] = 1'b1;
      end else if (v_c[i] < sat_min) begin
        y_d[i]   = sat_min[W-1:0];
        sat_c[i] = 1'b1;
      end
    end
  end

  logic signed [W-1:0] y_q [8];
  logic                ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
    end else begin
      if (en) begin
        y_valid_q <= v2_q;
        if (v2_q) begin
          for (int i = 0; i < 8; i++) y_q[i] <= y_d[i];
        end
      end
      // A new saturation event beats a same-cycle clear.
      ovf_q <= (ovf_q && !bus.cr_clear_overflow) || (en && v2_q && (|sat_c));
    end
  end

  assign bus.y_valid     = y_valid_q;
  assign bus.sr_overflow = ovf_q;
  assign bus.y_a_re      = y_q[0];
  assign bus.y_a_im      = y_q[1];
  assign bus.y_b_re      = y_q[2];
  assign bus.y_b_im      = y_q[3];
  assign bus.y_c_re      = y_q[4];
  assign bus.y_c_im      = y_q[5];
  assign bus.y_d_re      = y_q[6];
  assign bus.y_d_im      = y_q[7];
endmodule
